// File: rtl/mailbox_drain_if.sv
// Message stream from the mailbox drain agent to its consumer.
// A beat transfers on a rising edge where m_valid && m_ready; while m_valid is high
// and m_ready is low, m_data/m_addr hold steady, and both read 0 when m_valid is low.
interface mailbox_drain_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_addr;

    modport master (
        output m_valid,
        output m_data,
        output m_addr,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_addr,
        output m_ready
    );
endinterface

// File: rtl/mailbox_drain.sv
// Read-side agent for the mailbox RAM: sweeps a slot range with read-to-clear strobes
// and forwards every non-zero message, tagged with its slot, through a small FWFT FIFO.
module mailbox_drain #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int SCAN_LO    = 0,
    parameter int SCAN_HI    = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    output logic              re_o,
    output logic [ADDR_W-1:0] add_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              sweep_done_o,
    output logic [7:0]        msg_count_o,
    output logic [1:0]        state_o,
    mailbox_drain_if.master   m_if
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        STALL   = 2'd3
    } state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] LO       = ADDR_W'(SCAN_LO);
    localparam logic [ADDR_W-1:0] HI       = ADDR_W'(SCAN_HI);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              re_q;
    logic [ADDR_W-1:0] add_q;
    logic              sweep_done_q;
    logic [7:0]        msg_count_q;

    logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ENT_W-1:0]  head;
    logic              push, pop, full_q, full_d;

    assign push   = (state_q == CAPTURE) && (rd_data_i != '0);
    assign pop    = (count_q != '0) && m_if.m_ready;
    assign full_q = (count_q == FULL_CNT);
    assign full_d = (count_d == FULL_CNT);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Wrap on the range bounds rather than relying on address overflow.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == CAPTURE) begin
            ptr_d = (ptr_q == HI) ? LO : ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= LO;
            re_q         <= 1'b0;
            add_q        <= '0;
            sweep_done_q <= 1'b0;
            msg_count_q  <= '0;
        end else begin
            re_q         <= 1'b0;
            sweep_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en_i) begin
                        if (full_q) begin
                            state_q <= STALL;
                        end else begin
                            state_q <= ISSUE;
                            re_q    <= 1'b1;
                            add_q   <= ptr_q;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    ptr_q        <= ptr_d;
                    sweep_done_q <= (ptr_q == HI);
                    if (push && (msg_count_q != 8'hFF)) begin
                        msg_count_q <= msg_count_q + 8'd1;
                    end
                    // en low only stops new reads; this capture has already completed.
                    if (!en_i) begin
                        state_q <= IDLE;
                    end else if (full_d) begin
                        state_q <= STALL;
                    end else begin
                        state_q <= ISSUE;
                        re_q    <= 1'b1;
                        add_q   <= ptr_d;
                    end
                end
                STALL: begin
                    if (!en_i) begin
                        state_q <= IDLE;
                    end else if (!full_q) begin
                        state_q <= ISSUE;
                        re_q    <= 1'b1;
                        add_q   <= ptr_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {ptr_q, rd_data_i};
    end

    assign head           = fifo_q[rd_ptr_q];
    assign m_if.m_valid   = (count_q != '0);
    assign m_if.m_data    = m_if.m_valid ? head[DATA_W-1:0] : '0;
    assign m_if.m_addr    = m_if.m_valid ? head[ENT_W-1:DATA_W] : '0;

    assign re_o         = re_q;
    assign add_o        = add_q;
    assign sweep_done_o = sweep_done_q;
    assign msg_count_o  = msg_count_q;
    assign state_o      = state_q;

endmodule
